// File: rtl/hdmi_pattern_gen.sv
// Test-pattern generator that re-times HDMI syncs/DE through a 2-stage pipeline
// and replaces pixel data with solid, colour-bar, checkerboard or gradient patterns.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int BAR_W    = 160
) (
    input  logic        pix_clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [1:0]  mode_sel,
    input  logic [23:0] solid_rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [23:0] rgb_out,
    output logic [7:0]  frame_cnt,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    logic        de_prev;
    logic        vs_prev;
    logic        skip_line;
    logic        first_frame;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic [10:0] bar_pos;
    logic [2:0]  bar_idx;
    logic [1:0]  mode_act;

    logic        de_rise;
    logic        de_fall;
    logic        vs_rise;
    logic        line_done;
    logic [10:0] x_cur;
    logic [10:0] bar_pos_cur;
    logic [2:0]  bar_idx_cur;
    logic [10:0] y_inc;
    logic [10:0] lines_total;
    logic [11:0] run_len;

    logic        hs1;
    logic        vs1;
    logic        de1;
    logic [7:0]  x1;
    logic [7:0]  y1;
    logic [7:0]  fc1;
    logic [1:0]  mode1;
    logic [23:0] solid1;
    logic [2:0]  bar1;
    logic [23:0] pix_rgb;

    assign de_rise = de_in & ~de_prev;
    assign de_fall = ~de_in & de_prev;
    assign vs_rise = vsync_in & ~vs_prev;

    // A line already in progress when reset released is not length-checked or counted.
    assign line_done   = de_fall & ~skip_line;
    assign y_inc       = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 11'd1;
    assign lines_total = line_done ? y_inc : y_cnt;
    assign run_len     = {1'b0, x_cnt} + 12'd1;

    // Bar index tracked incrementally so no divider is needed.
    always_comb begin
        x_cur       = x_cnt;
        bar_pos_cur = bar_pos;
        bar_idx_cur = bar_idx;
        if (de_rise) begin
            x_cur       = 11'd0;
            bar_pos_cur = 11'd0;
            bar_idx_cur = 3'd0;
        end else begin
            if (x_cnt != CNT_MAX) begin
                x_cur = x_cnt + 11'd1;
            end
            if (bar_pos == BAR_LAST) begin
                bar_pos_cur = 11'd0;
                if (bar_idx != 3'd7) begin
                    bar_idx_cur = bar_idx + 3'd1;
                end
            end else begin
                bar_pos_cur = bar_pos + 11'd1;
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            de_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            skip_line   <= 1'b1;
            first_frame <= 1'b1;
            x_cnt       <= 11'd0;
            y_cnt       <= 11'd0;
            bar_pos     <= 11'd0;
            bar_idx     <= 3'd0;
            mode_act    <= 2'd1;
            frame_cnt   <= 8'd0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            de_prev <= de_in;
            vs_prev <= vsync_in;
            if (!de_in) begin
                skip_line <= 1'b0;
            end
            if (de_in) begin
                x_cnt   <= x_cur;
                bar_pos <= bar_pos_cur;
                bar_idx <= bar_idx_cur;
            end
            if (line_done && run_len != 12'(H_ACTIVE)) begin
                line_err <= 1'b1;
            end
            // A line ending on the frame-start cycle belongs to the finishing frame.
            if (vs_rise) begin
                if (!first_frame && lines_total != 11'(V_ACTIVE)) begin
                    frame_err <= 1'b1;
                end
                first_frame <= 1'b0;
                y_cnt       <= 11'd0;
                frame_cnt   <= frame_cnt + 8'd1;
                mode_act    <= mode_sel;
            end else if (line_done) begin
                y_cnt <= y_inc;
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            de1       <= 1'b0;
            x1        <= 8'd0;
            y1        <= 8'd0;
            fc1       <= 8'd0;
            mode1     <= 2'd0;
            solid1    <= 24'd0;
            bar1      <= 3'd0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            rgb_out   <= 24'd0;
        end else begin
            hs1       <= hsync_in;
            vs1       <= vsync_in;
            de1       <= de_in;
            x1        <= x_cur[7:0];
            y1        <= y_cnt[7:0];
            fc1       <= frame_cnt;
            mode1     <= mode_act;
            solid1    <= solid_rgb;
            bar1      <= bar_idx_cur;
            hsync_out <= hs1;
            vsync_out <= vs1;
            de_out    <= de1;
            rgb_out   <= de1 ? pix_rgb : 24'd0;
        end
    end

    always_comb begin
        pix_rgb = 24'd0;
        case (mode1)
            2'd0: pix_rgb = solid1;
            2'd1: begin
                case (bar1)
                    3'd0:    pix_rgb = 24'hFFFFFF;
                    3'd1:    pix_rgb = 24'hFFFF00;
                    3'd2:    pix_rgb = 24'h00FFFF;
                    3'd3:    pix_rgb = 24'h00FF00;
                    3'd4:    pix_rgb = 24'hFF00FF;
                    3'd5:    pix_rgb = 24'hFF0000;
                    3'd6:    pix_rgb = 24'h0000FF;
                    default: pix_rgb = 24'h000000;
                endcase
            end
            2'd2:    pix_rgb = (x1[5] ^ y1[5]) ? 24'h000000 : 24'hFFFFFF;
            default: pix_rgb = {x1, y1, fc1};
        endcase
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen: a small timing generator drives scaled-down
// frames, a behavioural model predicts each output pixel and the status flags.
module tb_hdmi_pattern_gen;

    localparam int H    = 80;
    localparam int V    = 36;
    localparam int BW   = 10;
    localparam int HTOT = 100;

    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        pix_clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        de_in = 1'b0;
    logic [1:0]  mode_sel = 2'd1;
    logic [23:0] solid_rgb = 24'd0;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic [23:0] rgb_out;
    logic [7:0]  frame_cnt;
    logic        line_err;
    logic        frame_err;

    hdmi_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW)) dut (
        .pix_clk   (pix_clk),
        .reset     (reset),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .mode_sel  (mode_sel),
        .solid_rgb (solid_rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .de_out    (de_out),
        .rgb_out   (rgb_out),
        .frame_cnt (frame_cnt),
        .line_err  (line_err),
        .frame_err (frame_err)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int m_x, m_y, m_fc, m_mode;
    bit m_pde, m_pvs, m_lerr, m_ferr, m_first, m_skip;

    function automatic logic [23:0] pattern(int mode, int x, int y, int fc, logic [23:0] solid);
        int b;
        case (mode)
            0: return solid;
            1: begin
                b = x / BW;
                if (b > 7) b = 7;
                return BARS[b];
            end
            2: return ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
        endcase
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_fc = 0; m_mode = 1;
        m_pde = 0; m_pvs = 0; m_lerr = 0; m_ferr = 0; m_first = 1; m_skip = 1;
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic de, output exp_t e);
        e.hs = hs; e.vs = vs; e.de = de; e.rgb = 24'd0;
        if (de) begin
            m_x = !m_pde ? 0 : ((m_x < 2047) ? m_x + 1 : 2047);
            e.rgb = pattern(m_mode, m_x, m_y, m_fc, solid_rgb);
        end
        if (!de && m_pde && !m_skip) begin
            if (m_x + 1 != H) m_lerr = 1;
            if (m_y < 2047) m_y++;
        end
        if (vs && !m_pvs) begin
            if (!m_first && m_y != V) m_ferr = 1;
            m_first = 0;
            m_y = 0;
            m_fc = (m_fc + 1) % 256;
            m_mode = int'(mode_sel);
        end
        if (!de) m_skip = 0;
        m_pde = de;
        m_pvs = vs;
    endtask

    task automatic status_check();
        vectors++;
        if (frame_cnt !== 8'(m_fc) || line_err !== m_lerr || frame_err !== m_ferr) begin
            miscompares++;
            $display("FAIL status @%0t: got frame_cnt=%0d line_err=%b frame_err=%b, expected frame_cnt=%0d line_err=%b frame_err=%b",
                     $time, frame_cnt, line_err, frame_err, m_fc, m_lerr, m_ferr);
        end
    endtask

    task automatic cyc(input logic hs, input logic vs, input logic de);
        exp_t e;
        @(negedge pix_clk);
        status_check();
        reset     = 1'b0;
        hsync_in  = hs;
        vsync_in  = vs;
        de_in     = de;
        solid_rgb = 24'($urandom);
        model_step(hs, vs, de, e);
        sb.push_back(e);
    endtask

    // The reset edge clears both pipeline stages, so the in-flight pixel is also blanked.
    task automatic reset_cyc(input logic hs, input logic vs, input logic de);
        @(negedge pix_clk);
        status_check();
        reset    = 1'b1;
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        if (sb.size() > 0) sb[sb.size() - 1] = '0;
        sb.push_back('0);
        model_reset();
    endtask

    task automatic line(input int len, input logic vs);
        for (int i = 0; i < HTOT; i++) begin
            cyc(i < 4, vs, (i >= 10) && (i < 10 + len));
        end
    endtask

    task automatic frame(input logic [1:0] mode, input int nlines, input int short_line,
                         input int sw_line, input logic [1:0] sw_mode);
        mode_sel = mode;
        line(0, 1'b1);
        line(0, 1'b1);
        for (int l = 0; l < nlines; l++) begin
            if (l == sw_line) mode_sel = sw_mode;
            line((l == short_line) ? H - 1 : H, 1'b0);
        end
        line(0, 1'b0);
        line(0, 1'b0);
    endtask

    task automatic tiny_frame();
        mode_sel = 2'd3;
        cyc(0, 1, 0); cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 1);
        cyc(0, 0, 0); cyc(0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge pix_clk);
            #1;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                vectors++;
                if ({hsync_out, vsync_out, de_out, rgb_out} !== e) begin
                    miscompares++;
                    $display("FAIL pixel_out @%0t: got hs=%b vs=%b de=%b rgb=%h, expected hs=%b vs=%b de=%b rgb=%h",
                             $time, hsync_out, vsync_out, de_out, rgb_out, e.hs, e.vs, e.de, e.rgb);
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (3) reset_cyc(0, 0, 0);
        frame(2'd1, V, -1, -1, 2'd0);
        frame(2'd0, V, -1, -1, 2'd0);
        frame(2'd1, V, -1, 20, 2'd2);
        frame(2'd2, V, -1, -1, 2'd0);
        frame(2'd3, V, -1, -1, 2'd0);
        repeat (2) frame(2'($urandom_range(0, 3)), V, -1, int'($urandom_range(0, V - 1)),
                         2'($urandom_range(0, 3)));
        frame(2'd3, V, 17, -1, 2'd0);
        frame(2'd2, V - 1, -1, -1, 2'd0);
        frame(2'd1, V, -1, -1, 2'd0);
        repeat (257) tiny_frame();
        frame(2'd3, V, -1, -1, 2'd0);
        mode_sel = 2'd1;
        for (int i = 0; i < HTOT; i++) begin
            if (i == 10 + 60) reset_cyc(i < 4, 1'b0, 1'b1);
            else cyc(i < 4, 1'b0, (i >= 10) && (i < 10 + H));
        end
        frame(2'd1, V, -1, -1, 2'd0);
        frame(2'd3, V, -1, -1, 2'd0);
        repeat (4) cyc(0, 0, 0);
        @(negedge pix_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdmi_pattern_gen.md
HDMI_PATTERN_GEN -- requirements
Module: hdmi_pattern_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL provide parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL provide parameter BAR_W, default 160, colour-bar width in pixels (H_ACTIVE/8).
REQ-004 pix_clk  input  1  pixel clock, 74.25 MHz; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 hsync_in  input  1  horizontal sync from timing generator, active-high.
REQ-007 vsync_in  input  1  vertical sync from timing generator, active-high.
REQ-008 de_in  input  1  data enable from timing generator, high during active pixels.
REQ-009 mode_sel  input  2  requested pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
REQ-010 solid_rgb  input  24  colour for mode 0, [23:16] R, [15:8] G, [7:0] B.
REQ-011 hsync_out, vsync_out, de_out  output  1 each  syncs/enable delayed to align with rgb_out.
REQ-012 rgb_out  output  24  pixel data to HDMI transmitter, same packing as solid_rgb.
REQ-013 frame_cnt  output  8  frames started since reset.
REQ-014 line_err  output  1  sticky: a DE run length differed from H_ACTIVE.
REQ-015 frame_err  output  1  sticky: a frame's DE line count differed from V_ACTIVE.

Function
REQ-016 Latency SHALL be exactly 2 pix_clk cycles: hsync_out/vsync_out/de_out/rgb_out at cycle n+2 reflect inputs at cycle n.
REQ-017 Pixel counter x (11 bit) SHALL be 0 on first de_in-high cycle of a line, +1 per subsequent de_in-high cycle, saturating at 2047.
REQ-018 Line counter y (11 bit) SHALL increment on each de_in falling edge (de_in=0, previous=1), saturating at 2047.
REQ-019 Frame start SHALL be vsync_in rising edge (vsync_in=1, previous=0); on it y SHALL clear to 0 and frame_cnt SHALL increment, wrapping 255->0.
REQ-020 Active mode SHALL load from mode_sel only on frame start; mode_sel changes mid-frame SHALL NOT affect the current frame.
REQ-021 When de_out=0, rgb_out SHALL be 24'h000000.
REQ-022 Mode 0: rgb_out = solid_rgb sampled with the pixel (same pipeline delay).
REQ-023 Mode 1: bar = min(x/BAR_W,7); colours 0..7 = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-024 Mode 2: rgb_out = FFFFFF when x[5] XOR y[5] = 0, else 000000 (32x32 squares).
REQ-025 Mode 3: R = x[7:0], G = y[7:0], B = frame_cnt value at pixel time.
REQ-026 On each de_in falling edge, line_err SHALL set if the completed run length != H_ACTIVE.
REQ-027 On frame start, frame_err SHALL set if lines counted since the previous frame start != V_ACTIVE; check skipped for the first frame start after reset.
REQ-028 line_err and frame_err SHALL clear only on reset.
REQ-029 Simultaneous de_in fall and vsync_in rise: line counted into finishing frame before the frame_err check, then y cleared.

Reset
REQ-030 While reset=1 at a pix_clk edge: x, y, frame_cnt, line_err, frame_err, pipeline registers, hsync_out, vsync_out, de_out, rgb_out SHALL become 0; active mode SHALL become 1 (colour bars); first-frame flag SHALL be set.
REQ-031 Reset asserted mid-line SHALL abort the line without setting line_err; first de_in rise after reset starts x at 0.

Verification
REQ-032 Drive 1650x750 720p timing, mode_sel=1 from reset -> pixels x=0..159 FFFFFF, x=160 FFFF00, x=1120..1279 000000; outputs delayed 2 cycles; no errors.
REQ-033 mode_sel=0, solid_rgb=FF6432 -> every de_out=1 pixel FF6432, blanking 000000.
REQ-034 Switch mode_sel 1->2 at line 300 -> rest of frame still bars; next frame pixel (x=32,y=0)=000000, (x=32,y=32)=FFFFFF.
REQ-035 Mode 3, 257 frame starts -> frame_cnt=1 (wrap), pixel (x=5,y=3) in that frame = 050301.
REQ-036 One line with DE run of 1279 pixels -> line_err=1 after that line, stays 1; frame_err=1 at next frame start (unless line count still 720 -> stays 0).
REQ-037 Assert reset for 1 cycle mid-line at x=600 -> next cycle all outputs 0, frame_cnt=0, no error flags set by truncated line.
